// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: request-side front end of the 8-bit ALU datapath.
// Takes one {op, a, b, cin} request at a time, drives the shared operand bus
// and the adder / subtracter / Booth multiplier / SRT divider control pins,
// sequences the selected unit, captures its result and returns it over a
// valid/ready response channel.
// Optional build macro: ALU_SEQ_FLAGS_EN adds {zero, negative} response flags;
// without it rsp_flags is tied to 2'b00 and no flag logic exists.
module alu_op_sequencer #(
  parameter int MULT_RST_CYCLES = 1,
  parameter int MULT_CYCLES     = 11,
  parameter int DIV_TIMEOUT     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic        req_cin,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic        op_cin,
  input  logic [7:0]  add_sum,
  input  logic        add_cout,
  input  logic [7:0]  sub_diff,
  input  logic        sub_borrow,
  output logic        mult_rst,
  input  logic [15:0] mult_product,
  output logic        div_start,
  input  logic        div_busy,
  input  logic [7:0]  div_quotient,
  input  logic [7:0]  div_remainder,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic [1:0]  rsp_flags
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // One shared counter serves the multiplier reset/run phases and the divider wait.
  localparam int CNT_MAX0 = (MULT_CYCLES > DIV_TIMEOUT) ? MULT_CYCLES : DIV_TIMEOUT;
  localparam int CNT_MAX  = (MULT_RST_CYCLES > CNT_MAX0) ? MULT_RST_CYCLES : CNT_MAX0;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_MULT_RST, S_MULT_RUN, S_DIV_START, S_DIV_ARM, S_DIV_WAIT, S_RESP
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      exec_res;

  // Adder/subtracter result as presented to the response channel.
  always_comb begin
    exec_res = (op_q == OP_ADD) ? {7'b0, add_cout, add_sum} : {7'b0, sub_borrow, sub_diff};
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [1:0] flags_q;
  logic [1:0] exec_flags;
  logic [1:0] mul_flags;
  logic [1:0] div_flags;
  logic [7:0] exec_lo;

  // {zero, negative} per unit; the divider is unsigned so never negative.
  always_comb begin
    exec_lo    = (op_q == OP_ADD) ? add_sum : sub_diff;
    exec_flags = {exec_lo == 8'd0, exec_lo[7]};
    mul_flags  = {mult_product == 16'd0, mult_product[15]};
    div_flags  = {div_quotient == 8'd0, 1'b0};
  end

  assign rsp_flags = flags_q;
`else
  assign rsp_flags = 2'b00;
`endif

  // Sequencer FSM; every control pin and response field is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_q       <= OP_ADD;
      cnt        <= '0;
      req_ready  <= 1'b0;
      op_a       <= 8'd0;
      op_b       <= 8'd0;
      op_cin     <= 1'b0;
      mult_rst   <= 1'b0;
      div_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 16'd0;
      rsp_err    <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q    <= 2'b00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          mult_rst  <= 1'b1;
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_a      <= req_a;
            op_b      <= req_b;
            op_cin    <= (req_op == OP_ADD) ? req_cin : 1'b0;
            op_q      <= req_op;
            cnt       <= '0;
            case (req_op)
              OP_ADD, OP_SUB: state <= S_EXEC;
              OP_MUL: begin
                state    <= S_MULT_RST;
                mult_rst <= 1'b0;
              end
              default: begin
                if (req_b == 8'd0) begin
                  // Divide by zero never reaches the divider.
                  state      <= S_RESP;
                  rsp_valid  <= 1'b1;
                  rsp_result <= 16'd0;
                  rsp_err    <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                  flags_q    <= 2'b00;
`endif
                end else begin
                  state     <= S_DIV_START;
                  div_start <= 1'b1;
                end
              end
            endcase
          end
        end
        S_EXEC: begin
          rsp_result <= exec_res;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
          flags_q    <= exec_flags;
`endif
          state      <= S_RESP;
        end
        S_MULT_RST: begin
          if (cnt == CNT_W'(MULT_RST_CYCLES - 1)) begin
            cnt      <= '0;
            mult_rst <= 1'b1;
            state    <= S_MULT_RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_MULT_RUN: begin
          if (cnt == CNT_W'(MULT_CYCLES - 1)) begin
            rsp_result <= mult_product;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            flags_q    <= mul_flags;
`endif
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DIV_START: begin
          div_start <= 1'b0;
          state     <= S_DIV_ARM;
        end
        S_DIV_ARM: begin
          // Give div_busy a cycle to rise before it is trusted.
          cnt   <= '0;
          state <= S_DIV_WAIT;
        end
        S_DIV_WAIT: begin
          if (!div_busy) begin
            rsp_result <= {div_remainder, div_quotient};
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            flags_q    <= div_flags;
`endif
            state      <= S_RESP;
          end else if (cnt == CNT_W'(DIV_TIMEOUT - 1)) begin
            rsp_result <= 16'd0;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            flags_q    <= 2'b00;
`endif
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer with behavioural
// stubs of the four arithmetic units and a plain-arithmetic reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_a = 8'd0;
  logic [7:0]  req_b = 8'd0;
  logic        req_cin = 1'b0;
  logic [7:0]  op_a, op_b;
  logic        op_cin;
  logic [7:0]  add_sum;
  logic        add_cout;
  logic [7:0]  sub_diff;
  logic        sub_borrow;
  logic        mult_rst;
  logic [15:0] mult_product;
  logic        div_start;
  logic        div_busy;
  logic [7:0]  div_quotient, div_remainder;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic [1:0]  rsp_flags;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .sub_diff(sub_diff), .sub_borrow(sub_borrow),
    .mult_rst(mult_rst), .mult_product(mult_product),
    .div_start(div_start), .div_busy(div_busy),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .rsp_flags(rsp_flags)
  );

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic [1:0]  flags;
    int          lat;      // edges from accept to rsp_valid visible
    int          mrst_lo;  // cycles mult_rst seen low
    int          ds;       // cycles div_start seen high
    int          acc;      // accept edge number
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int last_acc = 0;
  int hs_cycle = 0;
  int stall_n = 0;
  int div_delay = 1;
  logic stuck = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle++;

  // ---- unit stubs ----
  assign {add_cout, add_sum} = {1'b0, op_a} + {1'b0, op_b} + {8'd0, op_cin};
  logic [8:0] sub_full;
  assign sub_full   = {1'b0, op_a} - {1'b0, op_b};
  assign sub_diff   = sub_full[7:0];
  assign sub_borrow = ~sub_full[8];

  // Multiplier: product only meaningful once it has run long enough out of reset.
  int mcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) mcnt <= 0;
    else if (!mult_rst) mcnt <= 0;
    else if (mcnt < 100) mcnt <= mcnt + 1;
  end
  assign mult_product = (mult_rst && mcnt >= 10) ?
                        16'({{8{op_a[7]}}, op_a} * {{8{op_b[7]}}, op_b}) : 16'hDEAD;

  // Divider: busy for div_delay edges after start; garbage outputs while busy.
  int dcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_busy <= 1'b0; dcnt <= 0; div_quotient <= 8'd0; div_remainder <= 8'd0;
    end else if (div_start) begin
      div_busy <= 1'b1; dcnt <= div_delay; div_quotient <= 8'hA5; div_remainder <= 8'h5A;
    end else if (div_busy && !stuck) begin
      if (dcnt > 1) dcnt <= dcnt - 1;
      else begin
        div_busy      <= 1'b0;
        div_quotient  <= op_a / op_b;
        div_remainder <= op_a % op_b;
      end
    end
  end

  // Response back-pressure: random, with an optional forced stall.
  always @(posedge clk) begin
    #1;
    if (rsp_valid && stall_n > 0) begin
      rsp_ready = 1'b0;
      stall_n--;
    end else begin
      rsp_ready = ($urandom_range(3) != 0);
    end
  end

  // ---- monitor ----
  int rise = 0;
  int mlo = 0;
  int dsc = 0;
  logic prev_v = 1'b0;
  logic [15:0] held_res;
  logic held_err;
  logic [1:0] held_fl;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_v = 1'b0; mlo = 0; dsc = 0;
    end else begin
      if (!mult_rst) mlo++;
      if (div_start) dsc++;
      if (rsp_valid) begin
        chk("req_ready_in_resp", req_ready, 0);
        if (!prev_v) begin
          rise = cycle; held_res = rsp_result; held_err = rsp_err; held_fl = rsp_flags;
        end else begin
          chk("hold_result", rsp_result, held_res);
          chk("hold_err", rsp_err, held_err);
          chk("hold_flags", rsp_flags, held_fl);
        end
        if (rsp_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got result %0h with no request outstanding", rsp_result);
          end else begin
            e = q.pop_front();
            chk("result", rsp_result, e.res);
            chk("err", rsp_err, e.err);
            chk("flags", rsp_flags, e.flags);
            if (e.lat >= 0) chk("latency", rise - e.acc, e.lat);
            chk("mult_rst_low_cycles", mlo, e.mrst_lo);
            chk("div_start_cycles", dsc, e.ds);
          end
          hs_cycle = cycle + 1;
          mlo = 0; dsc = 0;
        end
      end
      prev_v = rsp_valid && !rsp_ready;
    end
  end

  // ---- reference model + driver ----
  // d > 0: divider busy for d edges; d < 0: divider stuck busy (timeout expected).
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input int d);
    exp_t e;
    int s, lo, sa, sb, w;
    logic zero, neg;
    sa = $signed(a);
    sb = $signed(b);
    e.err = 1'b0; e.mrst_lo = 0; e.ds = 0; zero = 1'b0; neg = 1'b0;
    case (op)
      2'd0: begin
        s = int'(a) + int'(b) + int'(cin);
        e.res = 16'(s); zero = (s % 256) == 0; neg = (s % 256) >= 128; e.lat = 1;
      end
      2'd1: begin
        lo = (int'(a) - int'(b) + 256) % 256;
        e.res = 16'(lo + ((a >= b) ? 256 : 0)); zero = lo == 0; neg = lo >= 128; e.lat = 1;
      end
      2'd2: begin
        s = sa * sb;
        e.res = 16'(s); zero = s == 0; neg = s < 0; e.lat = 12; e.mrst_lo = 1;
      end
      default: begin
        if (b == 8'd0) begin
          // Straight to the response state: valid in the cycle right after accept.
          e.res = 16'd0; e.err = 1'b1; e.lat = 0;
        end else if (d < 0) begin
          e.res = 16'd0; e.err = 1'b1; e.lat = 2 + 32; e.ds = 1;
        end else begin
          e.res = {8'(int'(a) % int'(b)), 8'(int'(a) / int'(b))};
          zero = (int'(a) / int'(b)) == 0; e.lat = d + 2; e.ds = 1;
        end
      end
    endcase
`ifdef ALU_SEQ_FLAGS_EN
    e.flags = e.err ? 2'b00 : {zero, neg};
`else
    e.flags = 2'b00;
`endif
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    w = 0;
    while (!req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready still 0 after %0d cycles", w);
      req_valid = 1'b0;
      return;
    end
    div_delay = (d > 0) ? d : 1;
    stuck = (d < 0);
    e.acc = cycle + 1;
    last_acc = e.acc;
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_a = 8'($urandom); req_b = 8'($urandom); req_cin = 1'($urandom);
    chk("op_a_bus", op_a, a);
    chk("op_b_bus", op_b, b);
    chk("op_cin_bus", op_cin, (op == 2'd0) ? cin : 1'b0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() > 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, 0 required", q.size());
    end
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] a, b;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_mult_rst", mult_rst, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_op_bus", {op_a, op_b, 7'd0, op_cin}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_mult_rst", mult_rst, 1);

    issue(2'd0, 8'd200, 8'd100, 1'b1, 0);  // 0x012D
    issue(2'd1, 8'd50, 8'd70, 1'b0, 0);    // 0x00EC
    issue(2'd2, 8'd253, 8'd6, 1'b1, 0);    // 0xFFEE
    issue(2'd3, 8'd27, 8'd5, 1'b0, 3);     // 0x0205
    issue(2'd3, 8'd42, 8'd0, 1'b1, 0);     // divide by zero
    drain();

    // Held response, then back-to-back request waiting on req_ready.
    stall_n = 5;
    issue(2'd3, 8'd100, 8'd10, 1'b0, 2);   // 0x000A
    issue(2'd0, 8'd1, 8'd2, 1'b0, 0);
    chk("accept_after_hs", last_acc, hs_cycle + 1);
    drain();

    // Divider stuck busy: timeout error.
    issue(2'd3, 8'd9, 8'd3, 1'b0, -1);
    drain();
    stuck = 1'b0;

    // Reset in the middle of a multiply.
    issue(2'd2, 8'd7, 8'd9, 1'b0, 0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_mult_rst", mult_rst, 0);
    q.delete();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("after_midrst_req_ready", req_ready, 1);
    chk("after_midrst_rsp_valid", rsp_valid, 0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(3));
      a  = 8'($urandom);
      b  = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
      issue(op, a, b, 1'($urandom), int'($urandom_range(1, 6)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
